i2cfifo_buf: RTL
================

I2CFIFO_BUF -- requirements
Module: i2cfifo_buf

Interface
REQ-001 SHALL have parameter DW, default 8: data width of both FIFOs, legal range 8..32.
REQ-002 SHALL have parameter DEPTH, default 16: entries per FIFO, power of two, legal range 4..256.
REQ-003 SHALL have derived parameter AW = log2(DEPTH); counts and thresholds are AW+1 bits wide.
REQ-004 SHALL have port clk_i, input, 1: the single clock; all state is rising-edge clocked.
REQ-005 SHALL have port i2c_rst_async, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port fifo_rst, input, 1: synchronous clear of both FIFOs.
REQ-007 SHALL have ports tx_we_i (in, 1) and tx_dat_i (in, DW): system-bus push into TX.
REQ-008 SHALL have ports tx_rd_i (in, 1) and tx_dat_o (out, DW): I2C-engine pop from TX.
REQ-009 SHALL have ports rx_we_i (in, 1) and rx_dat_i (in, DW): I2C-engine push into RX.
REQ-010 SHALL have ports rx_rd_i (in, 1) and rx_dat_o (out, DW): system-bus pop from RX.
REQ-011 SHALL have threshold inputs tx_ae_thr and rx_af_thr (in, AW+1 each).
REQ-012 SHALL have TX status outputs txfifo_e, txfifo_ae, txfifo_f (out, 1 each) and tx_cnt (out, AW+1).
REQ-013 SHALL have RX status outputs rxfifo_e, rxfifo_af, rxfifo_f (out, 1 each) and rx_cnt (out, AW+1).
REQ-014 SHALL have error outputs tx_ovf, tx_udf, rx_ovf, rx_udf (out, 1 each, sticky).
REQ-015 SHALL have err_clr (in, 1), irq_en (in, 4 bits: [0] txae, [1] rxaf, [2] ovf, [3] udf) and irq (out, 1).

Function
REQ-016 Each FIFO SHALL be first-word-fall-through: dat_o always presents the head entry combinationally from storage, with no added read latency.
REQ-017 A push SHALL write at wptr and a pop SHALL advance rptr on the same clock edge; pointers are AW bits and wrap from DEPTH-1 to 0.
REQ-018 Count SHALL update +1 on push only, -1 on pop only, and stay unchanged on simultaneous accepted push and pop.
REQ-019 All flags and counts SHALL be registered or derived from registered count, and SHALL reflect a push or pop on the cycle after the edge.
REQ-020 Flag definitions: e = (cnt==0); f = (cnt==DEPTH); txfifo_ae = (tx_cnt <= tx_ae_thr); rxfifo_af = (rx_cnt >= rx_af_thr).
REQ-021 Threshold boundaries: tx_ae_thr=0 asserts ae only when empty; rx_af_thr=0 asserts af permanently; thresholds above DEPTH are not clamped.
REQ-022 Push while full with no pop SHALL be dropped (storage and count unchanged) and SHALL set the sticky ovf flag.
REQ-023 Push while full with a simultaneous pop SHALL be accepted; count stays DEPTH.
REQ-024 Pop while empty SHALL be ignored and SHALL set the sticky udf flag; a simultaneous push is accepted and count becomes 1.
REQ-025 fifo_rst SHALL zero pointers, counts and sticky flags, and SHALL override any same-cycle push, pop or err_clr.
REQ-026 err_clr SHALL clear all four sticky flags; a same-cycle new error SHALL win, leaving that flag set.
REQ-027 irq SHALL be a registered OR of (txfifo_ae & irq_en[0]), (rxfifo_af & irq_en[1]), (any ovf & irq_en[2]) and (any udf & irq_en[3]).
REQ-028 irq SHALL lag its source by one cycle.
REQ-029 Storage contents SHALL NOT be reset; only pointers, counts, flags and irq are reset.

Reset
REQ-030 Asserting i2c_rst_async SHALL immediately force: pointers=0, tx_cnt=rx_cnt=0, txfifo_e=rxfifo_e=1, txfifo_f=rxfifo_f=0, all sticky flags=0, irq=0.
REQ-031 While in reset, txfifo_ae SHALL equal 1 and rxfifo_af SHALL equal (rx_af_thr==0).
REQ-032 Reset asserted mid-operation SHALL discard all buffered data, with no partial pointer update.
REQ-033 The first push or pop SHALL be honoured on the first rising edge after reset deassertion.

Verification (DW=8, DEPTH=16)
REQ-034 Push 0x00..0x0F into TX -> txfifo_f=1, tx_cnt=16; pop 16 -> tx_dat_o sequence 0x00..0x0F, txfifo_e=1.
REQ-035 Fill RX, then push 0xAA with no pop -> dropped, rx_ovf=1, rx_cnt=16; err_clr -> rx_ovf=0.
REQ-036 Fill TX, then push 0x55 with a simultaneous pop -> tx_cnt stays 16, and 0x55 is the last word out after 16 pops.
REQ-037 Pop empty RX with a simultaneous push of 0x3C -> rx_udf=1, rx_cnt=1, rx_dat_o=0x3C.
REQ-038 rx_af_thr=12, irq_en=4'b0010: push 11 words -> irq=0; 12th push -> irq=1 one cycle after rxfifo_af; one pop -> irq=0.
REQ-039 Hold 5 words in TX, then pulse fifo_rst together with a push -> tx_cnt=0, txfifo_e=1; a further pulse of i2c_rst_async mid-push leaves identical state.

Source files
------------

// File: rtl/i2cfifo_buf.sv
// Paired first-word-fall-through FIFOs between the system bus and an I2C engine.
// Channel 0 is TX (bus pushes, engine pops); channel 1 is RX (engine pushes, bus pops).
module i2cfifo_buf #(
  parameter int DW    = 8,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          i2c_rst_async,
  input  logic          fifo_rst,
  input  logic          tx_we_i,
  input  logic [DW-1:0] tx_dat_i,
  input  logic          tx_rd_i,
  output logic [DW-1:0] tx_dat_o,
  input  logic          rx_we_i,
  input  logic [DW-1:0] rx_dat_i,
  input  logic          rx_rd_i,
  output logic [DW-1:0] rx_dat_o,
  input  logic [AW:0]   tx_ae_thr,
  input  logic [AW:0]   rx_af_thr,
  output logic          txfifo_e,
  output logic          txfifo_ae,
  output logic          txfifo_f,
  output logic [AW:0]   tx_cnt,
  output logic          rxfifo_e,
  output logic          rxfifo_af,
  output logic          rxfifo_f,
  output logic [AW:0]   rx_cnt,
  output logic          tx_ovf,
  output logic          tx_udf,
  output logic          rx_ovf,
  output logic          rx_udf,
  input  logic          err_clr,
  input  logic [3:0]    irq_en,
  output logic          irq
);

  localparam logic [AW:0] FULL_CNT = {1'b1, {AW{1'b0}}};

  // Handshake: a push (we) or pop (rd) is a single-cycle strobe with no
  // back-pressure. A pop is taken when the FIFO holds data; a push is taken
  // when there is room or a pop frees a slot on the same edge. Refused
  // strobes are dropped and recorded in the sticky ovf/udf flags.
  logic [1:0]    w_we;
  logic [1:0]    w_rd;
  logic [DW-1:0] w_wdat [2];
  logic [DW-1:0] w_rdat [2];
  logic [AW:0]   w_cnt  [2];
  logic [1:0]    w_ovf;
  logic [1:0]    w_udf;
  logic          w_irq_src;
  logic          r_irq;

  assign w_we      = {rx_we_i, tx_we_i};
  assign w_rd      = {rx_rd_i, tx_rd_i};
  assign w_wdat[0] = tx_dat_i;
  assign w_wdat[1] = rx_dat_i;

  for (genvar g = 0; g < 2; g++) begin : g_ch
    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_cnt;
    logic          r_ovf;
    logic          r_udf;
    logic          w_empty;
    logic          w_full;
    logic          w_pop;
    logic          w_push;
    logic          w_ovf_evt;
    logic          w_udf_evt;

    assign w_empty   = (r_cnt == '0);
    assign w_full    = (r_cnt == FULL_CNT);
    assign w_pop     = w_rd[g] && !w_empty;
    assign w_push    = w_we[g] && (!w_full || w_pop);
    assign w_ovf_evt = w_we[g] && !w_push;
    assign w_udf_evt = w_rd[g] && w_empty;

    // Storage has no reset; only the pointers decide what is valid.
    always_ff @(posedge clk_i) begin
      if (w_push && !fifo_rst) begin
        r_mem[r_wptr] <= w_wdat[g];
      end
    end

    always_ff @(posedge clk_i or posedge i2c_rst_async) begin
      if (i2c_rst_async) begin
        r_wptr <= '0;
        r_rptr <= '0;
        r_cnt  <= '0;
      end else if (fifo_rst) begin
        r_wptr <= '0;
        r_rptr <= '0;
        r_cnt  <= '0;
      end else begin
        if (w_push) begin
          r_wptr <= r_wptr + 1'b1;
        end
        if (w_pop) begin
          r_rptr <= r_rptr + 1'b1;
        end
        if (w_push && !w_pop) begin
          r_cnt <= r_cnt + 1'b1;
        end else if (w_pop && !w_push) begin
          r_cnt <= r_cnt - 1'b1;
        end
      end
    end

    // A new error in the same cycle as err_clr keeps its flag set.
    always_ff @(posedge clk_i or posedge i2c_rst_async) begin
      if (i2c_rst_async) begin
        r_ovf <= 1'b0;
        r_udf <= 1'b0;
      end else if (fifo_rst) begin
        r_ovf <= 1'b0;
        r_udf <= 1'b0;
      end else begin
        if (w_ovf_evt) begin
          r_ovf <= 1'b1;
        end else if (err_clr) begin
          r_ovf <= 1'b0;
        end
        if (w_udf_evt) begin
          r_udf <= 1'b1;
        end else if (err_clr) begin
          r_udf <= 1'b0;
        end
      end
    end

    assign w_rdat[g] = r_mem[r_rptr];
    assign w_cnt[g]  = r_cnt;
    assign w_ovf[g]  = r_ovf;
    assign w_udf[g]  = r_udf;
  end

  assign tx_dat_o  = w_rdat[0];
  assign rx_dat_o  = w_rdat[1];
  assign tx_cnt    = w_cnt[0];
  assign rx_cnt    = w_cnt[1];
  assign tx_ovf    = w_ovf[0];
  assign rx_ovf    = w_ovf[1];
  assign tx_udf    = w_udf[0];
  assign rx_udf    = w_udf[1];

  // Thresholds are compared unclamped, so values above DEPTH behave literally.
  assign txfifo_e  = (tx_cnt == '0);
  assign txfifo_f  = (tx_cnt == FULL_CNT);
  assign txfifo_ae = (tx_cnt <= tx_ae_thr);
  assign rxfifo_e  = (rx_cnt == '0);
  assign rxfifo_f  = (rx_cnt == FULL_CNT);
  assign rxfifo_af = (rx_cnt >= rx_af_thr);

  assign w_irq_src = (txfifo_ae && irq_en[0])
                  || (rxfifo_af && irq_en[1])
                  || ((tx_ovf || rx_ovf) && irq_en[2])
                  || ((tx_udf || rx_udf) && irq_en[3]);

  always_ff @(posedge clk_i or posedge i2c_rst_async) begin
    if (i2c_rst_async) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= w_irq_src;
    end
  end

  assign irq = r_irq;

endmodule
